// File: rtl/lcd_timing_gen_if.sv
// Pixel-side bundle of the LCD timing generator: run/mode controls in, sync/DE/coordinates out.
// Test-pattern colour lanes exist only when LCD_TIMING_TPG_EN is defined.
interface lcd_timing_gen_if #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 600
);
  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic             en;
  logic             de_only;
  logic             hsync;
  logic             vsync;
  logic             data_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             line_start;
  logic             frame_start;
  logic             busy;
`ifdef LCD_TIMING_TPG_EN
  logic [7:0]       tpg_r;
  logic [7:0]       tpg_g;
  logic [7:0]       tpg_b;

  modport master (input en, de_only,
                  output hsync, vsync, data_en, col, row, line_start, frame_start, busy,
                  tpg_r, tpg_g, tpg_b);
  modport slave  (output en, de_only,
                  input hsync, vsync, data_en, col, row, line_start, frame_start, busy,
                  tpg_r, tpg_g, tpg_b);
`else
  modport master (input en, de_only,
                  output hsync, vsync, data_en, col, row, line_start, frame_start, busy);
  modport slave  (output en, de_only,
                  input hsync, vsync, data_en, col, row, line_start, frame_start, busy);
`endif
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised HV/DE panel timing generator with frame-boundary stop and runtime DE-only mode.
// Optional colour-bar test pattern on the bus when LCD_TIMING_TPG_EN is defined.
module lcd_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 160,
  parameter int   H_SYNC   = 1,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 12,
  parameter int   V_SYNC   = 1,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                clock,
  input  logic                reset_L,
  lcd_timing_gen_if.master    bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int COL_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_SYNC_END = HC_W'(H_SYNC);
  localparam logic [HC_W-1:0] HC_DE_FIRST = HC_W'(H_SYNC + H_BP);
  localparam logic [HC_W-1:0] HC_DE_LAST  = HC_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VC_W-1:0] VC_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_SYNC_END = VC_W'(V_SYNC);
  localparam logic [VC_W-1:0] VC_DE_FIRST = VC_W'(V_SYNC + V_BP);
  localparam logic [VC_W-1:0] VC_DE_LAST  = VC_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
    $error("lcd_timing_gen: H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be non-zero");
  end

  logic [1:0]      state_r, state_s;
  logic [HC_W-1:0] hc_r, hc_s;
  logic [VC_W-1:0] vc_r, vc_s;
  logic            mode_r, mode_s;
  logic            last_px_s;
  logic            run_s;
  logic            de_s;
  logic            hsync_s;
  logic            vsync_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;

  // Next-state: a frame always finishes; en is only honoured for stopping at the last pixel
  always_comb begin
    state_s   = state_r;
    hc_s      = hc_r;
    vc_s      = vc_r;
    mode_s    = mode_r;
    last_px_s = (hc_r == HC_LAST) && (vc_r == VC_LAST);
    case (state_r)
      ST_IDLE: begin
        hc_s = {HC_W{1'b0}};
        vc_s = {VC_W{1'b0}};
        if (bus.en) begin
          state_s = ST_RUN;
          mode_s  = bus.de_only;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (hc_r == HC_LAST) begin
          hc_s = {HC_W{1'b0}};
          if (vc_r == VC_LAST) begin
            vc_s = {VC_W{1'b0}};
          end else begin
            vc_s = vc_r + VC_W'(1);
          end
        end else begin
          hc_s = hc_r + HC_W'(1);
        end
        if (last_px_s) begin
          if (bus.en) begin
            state_s = ST_RUN;
            mode_s  = bus.de_only;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (bus.en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        hc_s    = {HC_W{1'b0}};
        vc_s    = {VC_W{1'b0}};
        mode_s  = 1'b0;
      end
    endcase
  end

  // Output decode of the current counters; everything idles at its reset level outside RUN/DRAIN
  always_comb begin
    run_s   = (state_r != ST_IDLE);
    de_s    = run_s && (hc_r >= HC_DE_FIRST) && (hc_r <= HC_DE_LAST)
                    && (vc_r >= VC_DE_FIRST) && (vc_r <= VC_DE_LAST);
    hsync_s = (run_s && !mode_r && (hc_r < HC_SYNC_END)) ? HS_POL : ~HS_POL;
    vsync_s = (run_s && !mode_r && (vc_r < VC_SYNC_END)) ? VS_POL : ~VS_POL;
    if (de_s) begin
      col_s = COL_W'(hc_r - HC_DE_FIRST);
      row_s = ROW_W'(vc_r - VC_DE_FIRST);
    end else begin
      col_s = {COL_W{1'b0}};
      row_s = {ROW_W{1'b0}};
    end
  end

  // Sequencer state and counters
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
      hc_r    <= {HC_W{1'b0}};
      vc_r    <= {VC_W{1'b0}};
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      hc_r    <= hc_s;
      vc_r    <= vc_s;
      mode_r  <= mode_s;
    end
  end

  // Registered timing outputs, one clock behind the counters
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      bus.hsync       <= ~HS_POL;
      bus.vsync       <= ~VS_POL;
      bus.data_en     <= 1'b0;
      bus.col         <= {COL_W{1'b0}};
      bus.row         <= {ROW_W{1'b0}};
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.hsync       <= hsync_s;
      bus.vsync       <= vsync_s;
      bus.data_en     <= de_s;
      bus.col         <= col_s;
      bus.row         <= row_s;
      bus.line_start  <= run_s && (hc_r == {HC_W{1'b0}});
      bus.frame_start <= run_s && (hc_r == {HC_W{1'b0}}) && (vc_r == {VC_W{1'b0}});
      bus.busy        <= run_s;
    end
  end

`ifdef LCD_TIMING_TPG_EN
  localparam int BAR_DIV = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  // Eight vertical bars, white..black, bar index clamped at the right edge
  function automatic logic [23:0] bar_colour(input logic [COL_W-1:0] c);
    int bar_v;
    bar_v = int'(c) / BAR_DIV;
    if (bar_v > 7) begin
      bar_v = 7;
    end else begin
      bar_v = bar_v;
    end
    case (bar_v)
      0:       bar_colour = 24'hFFFFFF;
      1:       bar_colour = 24'hFFFF00;
      2:       bar_colour = 24'h00FFFF;
      3:       bar_colour = 24'h00FF00;
      4:       bar_colour = 24'hFF00FF;
      5:       bar_colour = 24'hFF0000;
      6:       bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  logic [23:0] tpg_s;

  // Pattern pixel for the current position, blank outside the active area
  always_comb begin
    if (de_s) begin
      tpg_s = bar_colour(col_s);
    end else begin
      tpg_s = 24'h000000;
    end
  end

  // Pattern registers aligned with data_en
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      bus.tpg_r <= 8'h00;
      bus.tpg_g <= 8'h00;
      bus.tpg_b <= 8'h00;
    end else begin
      bus.tpg_r <= tpg_s[23:16];
      bus.tpg_g <= tpg_s[15:8];
      bus.tpg_b <= tpg_s[7:0];
    end
  end
`endif
endmodule
